solver_arbiter: RTL
===================

SOLVER_ARBITER -- requirements
Module: solver_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum number of cycles to wait for solver_valid after solver_enable before aborting.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0  in  1  requester 0 start pulse; operands are sampled on the same edge.
REQ-005 x0  in  8  requester 0 operand x, signed.
REQ-006 a0, b0, c0  in  16 each  requester 0 coefficients, signed.
REQ-007 busy0  out  1  requester 0 slot occupied (pending or in service).
REQ-008 done0  out  1  one-cycle pulse: the requester 0 result is on y/err.
REQ-009 req1, x1, a1, b1, c1, busy1, done1  as REQ-004..REQ-008, for requester 1.
REQ-010 y  out  16  signed result; valid only in a done cycle, holds otherwise.
REQ-011 err  out  1  qualifies done: 1 = timeout abort, 0 = good result.
REQ-012 idle  out  1  high when the FSM is in IDLE and both slots are empty.
REQ-013 solver_enable  out  1  one-cycle start pulse to the shared solver.
REQ-014 solver_x (8), solver_a, solver_b, solver_c (16 each)  out  registered operands to the solver.
REQ-015 solver_y  in  16  solver result.
REQ-016 solver_ready  in  1  solver idle, can accept a start.
REQ-017 solver_valid  in  1  solver result available; the result is taken on its rising edge.

Function
REQ-018 Request capture:
- When req_i=1 and busy_i=0 at an edge, the slot latches x_i/a_i/b_i/c_i and busy_i goes to 1.
- When busy_i=1, req_i is ignored, including in the done_i cycle.
REQ-019 States: IDLE, WAIT_VALID, WAIT_READY.
REQ-020 IDLE: if at least one slot is pending-not-served and solver_ready=1, then:
- select the owner;
- load solver_x/a/b/c from the owner's slot;
- assert solver_enable=1 for the next cycle only;
- clear the timeout counter;
- go to WAIT_VALID.
REQ-021 Arbitration: round-robin.
- If both slots are pending, serve the one not served last.
- The last-served pointer resets to 1, so requester 0 wins the first tie.
- If only one slot is pending, serve it.
REQ-022 solver_x/a/b/c hold stable from the solver_enable cycle until the state leaves WAIT_VALID.
REQ-023 valid_q registers solver_valid every cycle, in every state.
- The result is accepted only when, in WAIT_VALID, solver_valid=1 and valid_q=0.
- A level left high from a previous operation is never accepted.
REQ-024 Result accepted, on the same edge:
- y <= solver_y, err <= 0;
- done_owner pulses high for 1 cycle;
- busy_owner clears;
- pointer <= owner;
- state goes to WAIT_READY.
REQ-025 Timeout counter:
- Increments each WAIT_VALID cycle.
- If it reaches TIMEOUT-1 with no accepted edge: y <= 0, err <= 1, done_owner pulses, busy_owner clears, pointer updates, state goes to WAIT_READY.
- Counter width is clog2(TIMEOUT)+1, and it never wraps.
- A valid edge in the same cycle as the timeout takes precedence, i.e. it is a good result.
REQ-026 WAIT_READY: go to IDLE on the first cycle with solver_ready=1 and solver_valid=0.
- A new issue requires at least one cycle in IDLE.
- Back-to-back service of the other pending slot follows with no further gap.
REQ-027 At most one done_i is high per cycle; done0 and done1 are never simultaneous.
REQ-028 Latency, with an ideal solver of latency L: done_i is high L+2 cycles after req_i captures into an empty, idle arbiter.
REQ-029 No arithmetic is performed on operands or result: pure pass-through, sign preserved.

Reset
REQ-030 Reset, on any cycle including mid-operation:
- state = IDLE;
- busy0 = busy1 = 0, done0 = done1 = 0, solver_enable = 0;
- y = 0, err = 0, counter = 0, valid_q = 0, pointer = 1;
- solver_x/a/b/c = 0.
REQ-031 Reset discards pending and in-flight requests without issuing done. It does not drive any solver reset. A stale solver_valid after reset is ignored, because the FSM is not in WAIT_VALID.
REQ-032 req_i asserted during reset is ignored.

Verification
REQ-033 Single request: req0 with x0=2, a0=1, b0=2, c0=3; model solver computes a*x*x+b*x+c with L=4 -> one solver_enable with solver_x=2, solver_a=1, solver_b=2, solver_c=3; done0 with y=11, err=0; busy0 falls with done0.
REQ-034 Tie: req0 (x0=-1, a0=3, b0=0, c0=5) and req1 (x1=3, a1=0, b1=4, c1=-7) on the same edge -> done0 first with y=8, then done1 with y=5; exactly two solver_enable pulses.
REQ-035 Fairness: both requesters re-request immediately after each done, for 6 services -> grant order 0,1,0,1,0,1.
REQ-036 Timeout: TIMEOUT=8, solver never raises valid -> done0 with err=1 and y=0, 7 cycles after the solver_enable cycle; FSM then waits in WAIT_READY until solver_ready=1.
REQ-037 Stale valid: solver holds valid high across the next solver_enable -> no done until valid falls and rises again.
REQ-038 Mid-operation reset: reset asserted in WAIT_VALID -> next cycle idle=1, busy0=busy1=0, no done pulse; a fresh req1 afterwards is served normally.

Source files
------------

// File: rtl/solver_arbiter_if.sv
// Shared-solver bus between the arbiter and a single solver instance.
//   master : arbiter side; drives the start pulse and operands, receives result/status.
//   slave  : solver side; mirror of master.
// Signals:
//   solver_enable  one-cycle start pulse
//   solver_x       8-bit signed operand
//   solver_a/b/c   16-bit signed coefficients
//   solver_y       16-bit signed result
//   solver_ready   solver idle, can accept a start
//   solver_valid   result available (taken on its rising edge)
interface solver_arbiter_if;
  logic               solver_enable;
  logic signed [7:0]  solver_x;
  logic signed [15:0] solver_a;
  logic signed [15:0] solver_b;
  logic signed [15:0] solver_c;
  logic signed [15:0] solver_y;
  logic               solver_ready;
  logic               solver_valid;

  modport master (
    output solver_enable,
    output solver_x,
    output solver_a,
    output solver_b,
    output solver_c,
    input  solver_y,
    input  solver_ready,
    input  solver_valid
  );

  modport slave (
    input  solver_enable,
    input  solver_x,
    input  solver_a,
    input  solver_b,
    input  solver_c,
    output solver_y,
    output solver_ready,
    output solver_valid
  );
endinterface

// File: rtl/solver_arbiter.sv
// Two-requester round-robin arbiter in front of one shared solver.
// Each requester owns a one-entry slot: a start pulse latches its operands and
// holds the slot busy until a result (or timeout abort) is returned on y/err
// with a one-cycle done pulse for that requester.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   req0/x0/a0/b0/c0    requester 0 start pulse and operands
//   busy0, done0        requester 0 slot occupied / result strobe
//   req1 ... done1      same for requester 1
//   y, err              result and abort flag, meaningful in a done cycle
//   idle                FSM idle and both slots empty
//   sbus                shared solver bus (master side)
module solver_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               req0,
  input  logic signed [7:0]  x0,
  input  logic signed [15:0] a0,
  input  logic signed [15:0] b0,
  input  logic signed [15:0] c0,
  output logic               busy0,
  output logic               done0,

  input  logic               req1,
  input  logic signed [7:0]  x1,
  input  logic signed [15:0] a1,
  input  logic signed [15:0] b1,
  input  logic signed [15:0] c1,
  output logic               busy1,
  output logic               done1,

  output logic signed [15:0] y,
  output logic               err,
  output logic               idle,

  solver_arbiter_if.master   sbus
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitValid,
    StWaitReady
  } state_e;

  state_e             state_q;

  // Requester slots.
  logic               busy0_q, busy1_q;
  logic signed [7:0]  x0_q, x1_q;
  logic signed [15:0] a0_q, b0_q, c0_q;
  logic signed [15:0] a1_q, b1_q, c1_q;

  // Registered outputs.
  logic               done0_q, done1_q;
  logic signed [15:0] y_q;
  logic               err_q;
  logic               en_q;
  logic signed [7:0]  sx_q;
  logic signed [15:0] sa_q, sb_q, sc_q;

  // Service bookkeeping.
  logic               owner_q;  // slot currently in service
  logic               ptr_q;    // slot served last
  logic [CntW-1:0]    cnt_q;
  logic               valid_q;

  // Next-cycle helpers.
  logic               grant1;
  logic               valid_rise;
  logic [CntW-1:0]    cnt_inc;
  logic               tmo;

  always_comb begin
    // Tie goes to the slot not served last; otherwise whichever is pending.
    grant1 = 1'b0;
    if (busy0_q && busy1_q) begin
      grant1 = ~ptr_q;
    end else begin
      grant1 = busy1_q;
    end

    // Only a fresh 0->1 transition counts, so a level held over from an
    // earlier operation cannot complete the current one.
    valid_rise = sbus.solver_valid & ~valid_q;

    // Saturating so the counter can never wrap back into range.
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    tmo     = (cnt_inc >= CntLast);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      busy0_q <= 1'b0;
      busy1_q <= 1'b0;
      x0_q    <= '0;
      a0_q    <= '0;
      b0_q    <= '0;
      c0_q    <= '0;
      x1_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      c1_q    <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      y_q     <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      sx_q    <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      sc_q    <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sbus.solver_valid;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      en_q    <= 1'b0;

      if (req0 && !busy0_q) begin
        busy0_q <= 1'b1;
        x0_q    <= x0;
        a0_q    <= a0;
        b0_q    <= b0;
        c0_q    <= c0;
      end
      if (req1 && !busy1_q) begin
        busy1_q <= 1'b1;
        x1_q    <= x1;
        a1_q    <= a1;
        b1_q    <= b1;
        c1_q    <= c1;
      end

      unique case (state_q)
        StIdle: begin
          // In IDLE no slot is in service, so busy means pending.
          if ((busy0_q || busy1_q) && sbus.solver_ready) begin
            owner_q <= grant1;
            sx_q    <= grant1 ? x1_q : x0_q;
            sa_q    <= grant1 ? a1_q : a0_q;
            sb_q    <= grant1 ? b1_q : b0_q;
            sc_q    <= grant1 ? c1_q : c0_q;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= StWaitValid;
          end
        end

        StWaitValid: begin
          // A valid edge coinciding with the timeout still wins.
          if (valid_rise || tmo) begin
            y_q   <= valid_rise ? sbus.solver_y : '0;
            err_q <= ~valid_rise;
            if (owner_q) begin
              done1_q <= 1'b1;
              busy1_q <= 1'b0;
            end else begin
              done0_q <= 1'b1;
              busy0_q <= 1'b0;
            end
            ptr_q   <= owner_q;
            state_q <= StWaitReady;
          end else begin
            cnt_q <= cnt_inc;
          end
        end

        StWaitReady: begin
          if (sbus.solver_ready && !sbus.solver_valid) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy0 = busy0_q;
  assign busy1 = busy1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign y     = y_q;
  assign err   = err_q;
  assign idle  = (state_q == StIdle) && !busy0_q && !busy1_q;

  assign sbus.solver_enable = en_q;
  assign sbus.solver_x      = sx_q;
  assign sbus.solver_a      = sa_q;
  assign sbus.solver_b      = sb_q;
  assign sbus.solver_c      = sc_q;

endmodule
